// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder
// Turns a stream of pulse widths into Morse character codes. Each width is
// classified as a dot (width <= DOT_MAX) or a dash (width > DOT_MAX). Up to
// five symbols are packed MSB-first into out_code. A character is closed
// once GAP_CYCLES consecutive cycles pass without an accepted symbol.
// Symbols beyond the fifth are dropped and reported through out_err.
//
// Optional build macro: GLITCH_FILTER_EN
//   When defined, strobes whose width is below MIN_WIDTH are ignored
//   completely. Such a strobe behaves like an idle cycle.
//   When undefined, every strobe is processed.

module morse_symbol_decoder #(
  parameter int unsigned DOT_MAX    = 15,
  parameter int unsigned GAP_CYCLES = 100,
  parameter int unsigned MIN_WIDTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [10:0] data,
  output logic        out_valid,
  output logic [4:0]  out_code,
  output logic [2:0]  out_len,
  output logic        out_err
);

`ifdef GLITCH_FILTER_EN
  localparam logic GlitchEnC = 1'b1;
`else
  localparam logic GlitchEnC = 1'b0;
`endif

  localparam logic [10:0] DotMaxC   = 11'(DOT_MAX);
  localparam logic [10:0] MinWidthC = 11'(MIN_WIDTH);
  // Last gap count before the character closes. Clearing the counter at
  // this value keeps the 16-bit counter from ever wrapping.
  localparam logic [15:0] GapLastC  = 16'(GAP_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Architectural state.
  state_t      state_q, state_d;
  logic [4:0]  shift_q, shift_d;
  logic [2:0]  len_q, len_d;
  logic [15:0] gap_q, gap_d;
  logic        ovf_q, ovf_d;

  // Registered outputs.
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_code_q, out_code_d;
  logic [2:0]  out_len_q, out_len_d;
  logic        out_err_q, out_err_d;

  // Per-cycle symbol decode.
  logic        sym_s;
  logic        glitch_s;
  logic        accept_s;

  // Classify the incoming width and decide whether the strobe counts as a symbol.
  always_comb begin
    sym_s    = (data > DotMaxC);
    glitch_s = GlitchEnC && (data < MinWidthC);
    accept_s = ready && !glitch_s;
  end

  // Next-state logic: character assembly, gap timing and emission.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    len_d       = len_q;
    gap_d       = gap_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_code_d  = out_code_q;
    out_len_d   = out_len_q;
    out_err_d   = out_err_q;

    case (state_q)
      IDLE: begin
        gap_d = 16'd0;
        if (accept_s) begin
          shift_d = {4'b0000, sym_s};
          len_d   = 3'd1;
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end

      COLLECT: begin
        if (accept_s) begin
          // A new symbol always wins over a timeout in the same cycle.
          gap_d = 16'd0;
          if (len_q < 3'd5) begin
            shift_d = {shift_q[3:0], sym_s};
            len_d   = len_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (gap_q == GapLastC) begin
          out_valid_d = 1'b1;
          out_code_d  = shift_q;
          out_len_d   = len_q;
          out_err_d   = ovf_q;
          shift_d     = 5'd0;
          len_d       = 3'd0;
          gap_d       = 16'd0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      default: begin
        shift_d = 5'd0;
        len_d   = 3'd0;
        gap_d   = 16'd0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset discards any partial character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= 5'd0;
      len_q       <= 3'd0;
      gap_q       <= 16'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= 5'd0;
      out_len_q   <= 3'd0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_len_q   <= out_len_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_len   = out_len_q;
  assign out_err   = out_err_q;

endmodule
